// File: rtl/line_buffer_ctrl_pkg.sv
// Shared line-buffer configuration and controller state encodings.
// Depth derivation matches the one used for the line buffer itself.
package line_buffer_ctrl_pkg;

    localparam int LB_NO_TAPS     = 3;
    localparam int LB_TAPS_WIDTH  = 4;
    localparam int LB_DATA_LENGTH = 16;
    localparam int LB_CNT_LENGTH  = 8;

    function automatic int lb_depth(input int no_taps, input int taps_width);
        return no_taps * taps_width;
    endfunction

    typedef logic [2:0] lbc_state_t;

    localparam logic [2:0] LBC_IDLE  = 3'd0;
    localparam logic [2:0] LBC_CLEAR = 3'd1;
    localparam logic [2:0] LBC_FILL  = 3'd2;
    localparam logic [2:0] LBC_RUN   = 3'd3;
    localparam logic [2:0] LBC_DRAIN = 3'd4;
    localparam logic [2:0] LBC_DONE  = 3'd5;

endpackage

// File: rtl/line_buffer_ctrl_counter.sv
// Saturating up-counter with synchronous clear, used for fill and drain counts.
module lb_ctrl_counter #(
    parameter int                  pCntLength = 8,
    parameter logic [pCntLength-1:0] pMax     = '1
) (
    input  logic                  clk,
    input  logic                  clear_n,
    input  logic                  clr_i,
    input  logic                  inc_i,
    output logic [pCntLength-1:0] cnt_o
);

    logic [pCntLength-1:0] cnt_q;
    logic [pCntLength-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != pMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/line_buffer_ctrl.sv
// Line-buffer sequencing controller: clear, prime, stream, zero-drain, done.
// Holds no sample storage; the parent owns the line buffer itself.
//
//  state | meaning
//  IDLE  | waiting for start
//  CLEAR | one-cycle line-buffer clear, counters zeroed
//  FILL  | accepting samples until the taps are primed
//  RUN   | streaming, one shift per consumed window
//  DRAIN | pushing D zero samples through the taps
//  DONE  | one-cycle done pulse
module line_buffer_ctrl
    import line_buffer_ctrl_pkg::*;
#(
    parameter int pNoTaps     = LB_NO_TAPS,
    parameter int pTapsWidth  = LB_TAPS_WIDTH,
    parameter int pDataLength = LB_DATA_LENGTH,
    parameter int pCntLength  = LB_CNT_LENGTH
) (
    input  logic                   clk,
    input  logic                   clear_n,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [pDataLength-1:0] in_data,
    input  logic                   in_last,
    output logic                   lb_enable,
    output logic                   lb_clear,
    output logic [pDataLength-1:0] lb_shift_in,
    output logic                   taps_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done
);

    localparam int                    D     = lb_depth(pNoTaps, pTapsWidth);
    localparam logic [pCntLength-1:0] DEPTH = pCntLength'(D);

    lbc_state_t            state_q, state_d;
    logic                  pending_q, pending_d;
    logic [pCntLength-1:0] fill_cnt;
    logic [pCntLength-1:0] drain_cnt;
    logic                  primes;
    logic                  window_free;

    // A shift reaching depth D always yields a fresh window; fill_cnt saturates.
    assign primes      = (fill_cnt >= (DEPTH - 1'b1));
    assign window_free = !pending_q || out_ready;

    always_comb begin
        in_ready    = 1'b0;
        lb_enable   = 1'b0;
        lb_shift_in = '0;
        case (state_q)
            LBC_FILL: begin
                in_ready    = 1'b1;
                lb_enable   = in_valid;
                lb_shift_in = in_data;
            end
            LBC_RUN: begin
                in_ready    = window_free;
                lb_enable   = in_valid && window_free;
                lb_shift_in = in_data;
            end
            LBC_DRAIN: begin
                lb_enable = (drain_cnt != DEPTH) && window_free;
            end
            default: ;
        endcase
    end

    assign lb_clear   = (state_q == LBC_CLEAR);
    assign busy       = (state_q != LBC_IDLE);
    assign done       = (state_q == LBC_DONE);
    assign taps_valid = pending_q && ((state_q == LBC_RUN) || (state_q == LBC_DRAIN));

    always_comb begin
        pending_d = pending_q;
        if (state_q == LBC_CLEAR) begin
            pending_d = 1'b0;
        end else if (lb_enable && primes) begin
            pending_d = 1'b1;
        end else if (taps_valid && out_ready) begin
            pending_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LBC_IDLE:  if (start) state_d = LBC_CLEAR;
            LBC_CLEAR: state_d = LBC_FILL;
            LBC_FILL: begin
                if (lb_enable && in_last) begin
                    state_d = LBC_DRAIN;
                end else if (lb_enable && primes) begin
                    state_d = LBC_RUN;
                end
            end
            LBC_RUN:   if (lb_enable && in_last) state_d = LBC_DRAIN;
            LBC_DRAIN: if ((drain_cnt == DEPTH) && !pending_d) state_d = LBC_DONE;
            LBC_DONE:  state_d = LBC_IDLE;
            default:   state_d = LBC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= LBC_IDLE;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    lb_ctrl_counter #(
        .pCntLength (pCntLength),
        .pMax       (DEPTH)
    ) u_fill_cnt (
        .clk     (clk),
        .clear_n (clear_n),
        .clr_i   (lb_clear),
        .inc_i   (lb_enable),
        .cnt_o   (fill_cnt)
    );

    lb_ctrl_counter #(
        .pCntLength (pCntLength),
        .pMax       (DEPTH)
    ) u_drain_cnt (
        .clk     (clk),
        .clear_n (clear_n),
        .clr_i   (lb_clear),
        .inc_i   (lb_enable && (state_q == LBC_DRAIN)),
        .cnt_o   (drain_cnt)
    );

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Randomized bench for line_buffer_ctrl against a cycle-level protocol model
// plus per-line totals (shifts, windows, done pulses) derived from line length.
module tb_line_buffer_ctrl;

    localparam int D  = 12;
    localparam int DW = 16;

    localparam int M_IDLE  = 0;
    localparam int M_CLEAR = 1;
    localparam int M_FILL  = 2;
    localparam int M_RUN   = 3;
    localparam int M_DRAIN = 4;
    localparam int M_DONE  = 5;

    logic          clk = 1'b0;
    logic          clear_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          lb_enable;
    logic          lb_clear;
    logic [DW-1:0] lb_shift_in;
    logic          taps_valid;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          done;

    int n_pass = 0;
    int n_total = 0;

    // per-line statistics gathered from DUT outputs
    int sh_line = 0;
    int win_line = 0;
    int first_tv = -1;
    int clr_total = 0;
    int done_total = 0;
    int bad_shift = 0;
    bit cleared_since_rst = 1'b0;

    always #5 clk = ~clk;

    line_buffer_ctrl #(
        .pNoTaps     (3),
        .pTapsWidth  (4),
        .pDataLength (DW),
        .pCntLength  (8)
    ) dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .lb_enable   (lb_enable),
        .lb_clear    (lb_clear),
        .lb_shift_in (lb_shift_in),
        .taps_valid  (taps_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Compare process: model state advances on each negedge once inputs are settled.
    initial begin
        int  m_mode, m_fill, m_drain;
        bit  m_pend;
        int  nm, nf, nd;
        bit  np, e_ready, e_en, e_tv, feeding;
        m_mode = M_IDLE; m_fill = 0; m_drain = 0; m_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (!clear_n) begin
                m_mode = M_IDLE; m_fill = 0; m_drain = 0; m_pend = 1'b0;
                cleared_since_rst = 1'b0;
                check("rst_in_ready", in_ready, 0);
                check("rst_lb_enable", lb_enable, 0);
                check("rst_taps_valid", taps_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_lb_clear", lb_clear, 0);
                check("rst_lb_shift_in", lb_shift_in, 0);
            end else begin
                feeding = (m_mode == M_FILL) || (m_mode == M_RUN);
                e_ready = (m_mode == M_FILL) || (m_mode == M_RUN && (!m_pend || out_ready));
                e_en    = (feeding && in_valid && e_ready) ||
                          (m_mode == M_DRAIN && m_drain < D && (!m_pend || out_ready));
                e_tv    = m_pend && (m_mode == M_RUN || m_mode == M_DRAIN);
                check("in_ready", in_ready, e_ready);
                check("lb_enable", lb_enable, e_en);
                check("taps_valid", taps_valid, e_tv);
                check("lb_clear", lb_clear, m_mode == M_CLEAR);
                check("busy", busy, m_mode != M_IDLE);
                check("done", done, m_mode == M_DONE);
                check("lb_shift_in", lb_shift_in, feeding ? longint'(in_data) : 0);

                if (lb_clear) begin
                    clr_total++; sh_line = 0; win_line = 0; first_tv = -1;
                    cleared_since_rst = 1'b1;
                end
                if (taps_valid && first_tv < 0) first_tv = sh_line;
                if (taps_valid && out_ready) win_line++;
                if (lb_enable) begin
                    sh_line++;
                    if (!cleared_since_rst) bad_shift++;
                end
                if (done) done_total++;

                nm = m_mode; nf = m_fill; nd = m_drain; np = m_pend;
                if (e_en) nf = (m_fill < D) ? m_fill + 1 : D;
                if (e_en && nf == D) np = 1'b1;
                else if (e_tv && out_ready) np = 1'b0;
                case (m_mode)
                    M_IDLE:  if (start) nm = M_CLEAR;
                    M_CLEAR: begin nm = M_FILL; nf = 0; nd = 0; np = 1'b0; end
                    M_FILL: begin
                        if (e_en && in_last) nm = M_DRAIN;
                        else if (e_en && nf == D) nm = M_RUN;
                    end
                    M_RUN:   if (e_en && in_last) nm = M_DRAIN;
                    M_DRAIN: begin
                        if (e_en) nd = m_drain + 1;
                        if (m_drain == D && !np) nm = M_DONE;
                    end
                    default: nm = M_IDLE;
                endcase
                m_mode = nm; m_fill = nf; m_drain = nd; m_pend = np;
            end
        end
    end

    // Runs one complete line of n samples. vp/rp are valid/ready percentages.
    task automatic run_line(input string tag, input int n, input int vp, input int rp,
                            input bit stall5, input bit start_mid,
                            input int exp_sh, input int exp_win);
        int idx = 0;
        int cyc = 0;
        int stall_left = 5;
        bit seen_tv = 1'b0;
        bit stalling;
        bit acc;
        bit fin = 1'b0;
        int clr0, done0;
        clr0 = clr_total; done0 = done_total;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        while (!fin && cyc < 3000) begin
            stalling = stall5 && seen_tv && (stall_left > 0);
            in_valid = (idx < n) && (stalling || ($urandom_range(99) < vp));
            in_data  = DW'($urandom);
            in_last  = in_valid && (idx == n - 1);
            out_ready = stalling ? 1'b0 : ($urandom_range(99) < rp);
            start    = start_mid && (cyc == 20);
            @(negedge clk);
            if (stalling) begin
                check({tag, "_stall_lb_enable"}, lb_enable, 0);
                check({tag, "_stall_in_ready"}, in_ready, 0);
                check({tag, "_stall_taps_valid"}, taps_valid, 1);
                stall_left--;
            end
            if (taps_valid) seen_tv = 1'b1;
            acc = in_valid && in_ready;
            if (done) fin = 1'b1;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        if (!fin) $display("FAIL %s_timeout: got no done, expected done within 3000 cycles", tag);
        n_total++;
        if (fin) n_pass++;
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_samples"}, idx, n);
        check({tag, "_clear_cycles"}, clr_total - clr0, 1);
        check({tag, "_done_pulses"}, done_total - done0, 1);
        check({tag, "_shifts"}, sh_line, n + D);
        check({tag, "_windows"}, win_line, n + 1);
        check({tag, "_first_tv_shift"}, first_tv, D);
        check({tag, "_idle_after"}, busy, 0);
        if (exp_sh > 0) begin
            check({tag, "_shifts_lit"}, sh_line, exp_sh);
            check({tag, "_windows_lit"}, win_line, exp_win);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 clear_n = 1'b1;
        repeat (2) @(posedge clk);

        run_line("s1_full", 20, 100, 100, 1'b0, 1'b0, 32, 21);
        run_line("s2_stall", 20, 100, 100, 1'b1, 1'b0, 32, 21);
        run_line("s3_short", 7, 100, 100, 1'b0, 1'b0, 19, 8);
        check("s3_tv_on_drain_shift", first_tv - 7, 5);
        run_line("s4_last_at_prime", 12, 100, 100, 1'b0, 1'b0, 24, 13);

        // mid-RUN asynchronous reset
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = DW'($urandom);
            @(posedge clk); #1;
        end
        check("s5_busy_before_rst", busy, 1);
        clear_n = 1'b0;
        #1;
        check("s5_rst_in_ready", in_ready, 0);
        check("s5_rst_lb_enable", lb_enable, 0);
        check("s5_rst_taps_valid", taps_valid, 0);
        check("s5_rst_busy", busy, 0);
        check("s5_rst_done", done, 0);
        check("s5_rst_lb_clear", lb_clear, 0);
        check("s5_rst_lb_shift_in", lb_shift_in, 0);
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 clear_n = 1'b1;
        run_line("s5_after_rst", 15, 70, 60, 1'b0, 1'b0, 27, 16);
        check("s5_no_shift_before_clear", bad_shift, 0);

        run_line("s6_start_mid", 20, 100, 100, 1'b0, 1'b1, 32, 21);

        for (int k = 0; k < 8; k++) begin
            run_line("rnd", int'($urandom_range(40, 1)), int'($urandom_range(100, 30)),
                     int'($urandom_range(100, 30)), 1'b0, 1'b0, 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
